// File: rtl/wptr_full_ctrl_if.sv
// Write-side FIFO pointer bus: producer request, synchronized read pointer,
// and the write address / pointer / status flags returned by the controller.
interface wptr_full_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   wq2_rptr_gray;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic                  wr_accept;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_count;
  logic                  overflow;
  logic                  overflow_sticky;

  modport master (
    output wr_en, wq2_rptr_gray,
    input  waddr, wptr_gray, wr_accept, full, almost_full,
           wr_count, overflow, overflow_sticky
  );

  modport slave (
    input  wr_en, wq2_rptr_gray,
    output waddr, wptr_gray, wr_accept, full, almost_full,
           wr_count, overflow, overflow_sticky
  );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Async-FIFO write-pointer controller: binary/Gray write pointer, registered
// full / almost_full / occupancy flags against the synchronized read pointer.
module wptr_full_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  wptr_full_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH:0]   r_wbin;
  logic [ADDR_WIDTH:0]   r_wgray;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_af;
  logic                  r_ovf;
  logic                  r_ovf_sticky;

  logic                  w_accept;
  logic [ADDR_WIDTH:0]   w_wbin_next;
  logic [ADDR_WIDTH:0]   w_wgray_next;
  logic [ADDR_WIDTH:0]   w_rbin;
  logic [ADDR_WIDTH:0]   w_full_cmp;
  logic [ADDR_WIDTH:0]   w_count_next;
  logic [ADDR_WIDTH+1:0] w_free_next;
  logic                  w_full_next;
  logic                  w_af_next;

  // Gated by reset_n so nothing can strobe the RAM while the block is held.
  assign w_accept     = bus.wr_en & ~r_full & reset_n;
  assign w_wbin_next  = r_wbin + {{ADDR_WIDTH{1'b0}}, w_accept};
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

  genvar gi;
  generate
    for (gi = 0; gi <= ADDR_WIDTH; gi++) begin : g_gray2bin
      assign w_rbin[gi] = ^bus.wq2_rptr_gray[ADDR_WIDTH:gi];
    end
  endgenerate

  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  assign w_full_cmp   = {~bus.wq2_rptr_gray[ADDR_WIDTH:ADDR_WIDTH-1],
                         bus.wq2_rptr_gray[ADDR_WIDTH-2:0]};
  assign w_full_next  = (w_wgray_next == w_full_cmp);
  assign w_count_next = w_wbin_next - w_rbin;
  assign w_free_next  = (ADDR_WIDTH+2)'(DEPTH) - {1'b0, w_count_next};
  assign w_af_next    = (w_free_next <= (ADDR_WIDTH+2)'(AF_MARGIN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wbin       <= '0;
      r_wgray      <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_af         <= 1'b0;
      r_ovf        <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else begin
      r_wbin       <= w_wbin_next;
      r_wgray      <= w_wgray_next;
      r_count      <= w_count_next;
      r_full       <= w_full_next;
      r_af         <= w_af_next;
      r_ovf        <= bus.wr_en & r_full;
      r_ovf_sticky <= r_ovf_sticky | (bus.wr_en & r_full);
    end
  end

  assign bus.waddr           = r_wbin[ADDR_WIDTH-1:0];
  assign bus.wptr_gray       = r_wgray;
  assign bus.wr_accept       = w_accept;
  assign bus.full            = r_full;
  assign bus.almost_full     = r_af;
  assign bus.wr_count        = r_count;
  assign bus.overflow        = r_ovf;
  assign bus.overflow_sticky = r_ovf_sticky;
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl at ADDR_WIDTH=2, AF_MARGIN=1.
module tb_wptr_full_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [2:0] gtab [8];
  logic [2:0] prev_gray;

  always #5 clk = ~clk;

  wptr_full_ctrl_if #(.ADDR_WIDTH(2)) bus ();

  wptr_full_ctrl #(.ADDR_WIDTH(2), .AF_MARGIN(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] waddr, input logic [2:0] gray,
                             input logic [2:0] count, input logic full, input logic af);
    check_eq({tag, ".waddr"}, 32'(bus.waddr), 32'(waddr));
    check_eq({tag, ".gray"},  32'(bus.wptr_gray), 32'(gray));
    check_eq({tag, ".count"}, 32'(bus.wr_count), 32'(count));
    check_eq({tag, ".full"},  32'(bus.full), 32'(full));
    check_eq({tag, ".af"},    32'(bus.almost_full), 32'(af));
    $display("%0t %s waddr=%b gray=%b count=%0d full=%b af=%b ovf=%b sticky=%b", $time, tag,
             bus.waddr, bus.wptr_gray, bus.wr_count, bus.full, bus.almost_full,
             bus.overflow, bus.overflow_sticky);
  endtask

  task automatic check_ovf(input string tag, input logic ovf, input logic sticky);
    check_eq({tag, ".ovf"},    32'(bus.overflow), 32'(ovf));
    check_eq({tag, ".sticky"}, 32'(bus.overflow_sticky), 32'(sticky));
  endtask

  // Drive inputs on the falling edge, sample just after the rising edge.
  task automatic step(input logic wr, input logic [2:0] rg);
    @(negedge clk);
    bus.wr_en         = wr;
    bus.wq2_rptr_gray = rg;
    @(posedge clk);
    #1;
  endtask

  initial begin
    gtab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    reset_n           = 1'b0;
    bus.wr_en         = 1'b1;
    bus.wq2_rptr_gray = 3'b000;
    #2;
    check_state("reset", 2'd0, 3'b000, 3'd0, 1'b0, 1'b0);
    check_ovf("reset", 1'b0, 1'b0);
    check_eq("reset.accept", 32'(bus.wr_accept), 32'd0);

    @(negedge clk);
    bus.wr_en = 1'b0;
    reset_n   = 1'b1;

    step(1'b1, 3'b000); check_state("wr1", 2'd1, 3'b001, 3'd1, 1'b0, 1'b0);
    step(1'b1, 3'b000); check_state("wr2", 2'd2, 3'b011, 3'd2, 1'b0, 1'b0);
    step(1'b1, 3'b000); check_state("wr3", 2'd3, 3'b010, 3'd3, 1'b0, 1'b1);
    step(1'b1, 3'b000); check_state("wr4", 2'd0, 3'b110, 3'd4, 1'b1, 1'b1);

    // Write attempt while full is dropped and flagged.
    @(negedge clk);
    bus.wr_en = 1'b1;
    #1;
    check_eq("ovf.accept", 32'(bus.wr_accept), 32'd0);
    @(posedge clk);
    #1;
    check_state("ovf", 2'd0, 3'b110, 3'd4, 1'b1, 1'b1);
    check_ovf("ovf", 1'b1, 1'b1);
    step(1'b0, 3'b000);
    check_ovf("ovf_after", 1'b0, 1'b1);

    step(1'b0, 3'b001); check_state("rd1", 2'd0, 3'b110, 3'd3, 1'b0, 1'b1);

    @(negedge clk);
    bus.wr_en = 1'b1;
    #1;
    check_eq("refill.accept", 32'(bus.wr_accept), 32'd1);
    @(posedge clk);
    #1;
    check_state("refill", 2'd1, 3'b111, 3'd4, 1'b1, 1'b1);
    check_ovf("refill", 1'b0, 1'b1);

    // Reset between edges while a write request is still held.
    step(1'b1, 3'b001);
    #3;
    reset_n = 1'b0;
    #1;
    check_state("midrst", 2'd0, 3'b000, 3'd0, 1'b0, 1'b0);
    check_ovf("midrst", 1'b0, 1'b0);
    check_eq("midrst.accept", 32'(bus.wr_accept), 32'd0);
    bus.wr_en         = 1'b0;
    bus.wq2_rptr_gray = 3'b000;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 3'b000); check_state("postrst", 2'd1, 3'b001, 3'd1, 1'b0, 1'b0);

    // Writes paced by a read pointer one behind: wraps 111 -> 000 with no full.
    prev_gray = bus.wptr_gray;
    for (int k = 2; k <= 8; k++) begin
      step(1'b1, gtab[k-1]);
      check_state($sformatf("wrap%0d", k), 2'(k % 4), gtab[k % 8], 3'd1, 1'b0, 1'b0);
      check_eq($sformatf("wrap%0d.flips", k), 32'($countones(bus.wptr_gray ^ prev_gray)), 32'd1);
      prev_gray = bus.wptr_gray;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
